// File: rtl/act_pkg.sv
// act_pkg
// Shared types and defaults for the activation collect buffer.
//   bank_state_e   : per-bank occupancy state (EMPTY / FILLING / FULL)
//   DATA_WIDTH_DEF : default activation word width (IEEE-754 single)
package act_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line
// Shift register that delays a valid strobe by LAT cycles so it lines up
// with the output of a fixed-latency datapath stage.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset, clears every stage
//   i_valid : strobe entering the delayed stage
//   o_valid : strobe after LAT cycles
module valid_delay_line #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  output logic o_valid
);

  logic [LAT-1:0] r_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
    end else begin
      r_shift[0] <= i_valid;
      for (int i = 1; i < LAT; i++) begin
        r_shift[i] <= r_shift[i-1];
      end
    end
  end

  assign o_valid = r_shift[LAT-1];

endmodule

// File: rtl/act_collect_buffer.sv
// act_collect_buffer
// Collects ReLU activations into DEPTH-word vectors using two ping-pong
// banks and streams completed vectors to the next layer over a
// valid/ready interface.
//
// Bank states:
//   state        | meaning
//   BANK_EMPTY   | no data, may be filled
//   BANK_FILLING | partially written by the fill side
//   BANK_FULL    | complete vector, owned by the drain side until its last word leaves
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   z_valid   : pre-activation presented to the upstream ReLU stage
//   a         : ReLU output, valid RELU_LAT cycles after z_valid
//   out_data  : activation word to the next layer (registered)
//   out_valid : out_data valid
//   out_ready : downstream accepts out_data
//   out_last  : final word of a vector
//   overflow  : sticky, an activation was dropped because both banks were full
module act_collect_buffer
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 16,
  parameter int RELU_LAT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  z_valid,
  input  logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  overflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [2][DEPTH];
  bank_state_e           r_state [2];
  bank_state_e           w_state_nxt [2];

  logic                  r_fill_sel;
  logic                  r_drain_sel;
  logic [IDX_W-1:0]      r_wr_idx;
  logic [IDX_W-1:0]      r_rd_idx;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_overflow;

  logic                  w_cap_en;
  logic                  w_xfer;
  logic                  w_drain_done;
  logic                  w_fill_free;
  logic                  w_wr_en;
  logic                  w_drop;
  logic                  w_fill_done;
  logic                  w_other;
  logic [IDX_W-1:0]      w_rd_next;

  valid_delay_line #(
    .LAT (RELU_LAT)
  ) u_valid_delay (
    .clk     (clk),
    .rst     (rst),
    .i_valid (z_valid),
    .o_valid (w_cap_en)
  );

  assign w_xfer       = r_out_valid & out_ready;
  assign w_drain_done = w_xfer & (r_rd_idx == LAST_IDX);
  // A bank whose last word leaves this cycle is free for the fill side in
  // the same cycle; without this, continuous streaming would drop a word.
  assign w_fill_free  = (r_state[r_fill_sel] != BANK_FULL) ||
                        (w_drain_done && (r_drain_sel == r_fill_sel));
  assign w_wr_en      = w_cap_en & w_fill_free;
  assign w_drop       = w_cap_en & ~w_fill_free;
  assign w_fill_done  = w_wr_en & (r_wr_idx == LAST_IDX);
  assign w_other      = ~r_drain_sel;
  assign w_rd_next    = r_rd_idx + IDX_W'(1);

  // Drain release is applied before the fill update so a bank freed and
  // refilled in the same cycle ends up FILLING.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_state_nxt[b] = r_state[b];
      if (w_drain_done && (r_drain_sel == 1'(b))) begin
        w_state_nxt[b] = BANK_EMPTY;
      end
      if (w_wr_en && (r_fill_sel == 1'(b))) begin
        w_state_nxt[b] = w_fill_done ? BANK_FULL : BANK_FILLING;
      end
    end
  end

  // Bank storage: synchronous write, no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_fill_sel][r_wr_idx] <= a;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        r_state[b] <= BANK_EMPTY;
      end
      r_fill_sel <= 1'b0;
      r_wr_idx   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_wr_en) begin
        if (w_fill_done) begin
          r_wr_idx   <= '0;
          r_fill_sel <= ~r_fill_sel;
        end else begin
          r_wr_idx <= r_wr_idx + IDX_W'(1);
        end
      end
    end
  end

  // Output register holds drain bank[rd_idx]; it only reloads when empty or
  // when the current word is accepted, which keeps it stable under stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drain_sel <= 1'b0;
      r_rd_idx    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_xfer) begin
      if (w_drain_done) begin
        r_rd_idx    <= '0;
        r_drain_sel <= w_other;
        r_out_last  <= 1'b0;
        // Look ahead into the other bank so back-to-back vectors need no bubble.
        if (r_state[w_other] == BANK_FULL) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_mem[w_other][0];
        end else begin
          r_out_valid <= 1'b0;
        end
      end else begin
        r_rd_idx   <= w_rd_next;
        r_out_data <= r_mem[r_drain_sel][w_rd_next];
        r_out_last <= (w_rd_next == LAST_IDX);
      end
    end else if (!r_out_valid && (r_state[r_drain_sel] == BANK_FULL)) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_mem[r_drain_sel][r_rd_idx];
      r_out_last  <= (r_rd_idx == LAST_IDX);
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_act_collect_buffer.sv
module tb_act_collect_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  localparam logic [31:0] F0 = 32'h0000_0000;
  localparam logic [31:0] F1 = 32'h3F80_0000;
  localparam logic [31:0] F2 = 32'h4000_0000;
  localparam logic [31:0] F3 = 32'h4040_0000;
  localparam logic [31:0] F5 = 32'h40A0_0000;
  localparam logic [31:0] F6 = 32'h40C0_0000;
  localparam logic [31:0] F7 = 32'h40E0_0000;
  localparam logic [31:0] F8 = 32'h4100_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          z_valid = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          overflow;

  act_collect_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .RELU_LAT   (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .z_valid   (z_valid),
    .a         (a),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // upstream ReLU model: pure LAT-cycle delay of z plus max(z, 0)
  logic        hist_v [LAT];
  logic [31:0] hist_d [LAT];

  // reference model: accepted words in order, completed-vector bookkeeping
  logic [31:0] exp_q [$];
  int          comp_q [$];
  int          fill_cnt;
  int          out_pos;
  int          prev_rel;
  logic        m_ovf;
  logic        prev_stall;
  logic [31:0] prev_d;
  logic        prev_l;
  logic [31:0] out_log [$];
  logic        last_log [$];
  int          last_cnt;

  typedef struct {
    logic        zv;
    logic [31:0] zd;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        el;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [31:0] relu(input logic [31:0] z);
    return z[31] ? 32'h0 : z;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    comp_q.delete();
    out_log.delete();
    last_log.delete();
    fill_cnt   = 0;
    out_pos    = 0;
    last_cnt   = 0;
    m_ovf      = 1'b0;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;
    prev_rel   = cyc;
    for (int i = 0; i < LAT; i++) begin
      hist_v[i] = 1'b0;
      hist_d[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; z_valid = 1'b0; out_ready = 1'b0; a = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last",  out_last,  0);
    check("rst_overflow",  overflow,  0);
    check("rst_out_data",  out_data,  0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_model();
  endtask

  // One clock cycle: check outputs left by the previous edge, drive inputs,
  // advance the reference model for the coming edge, then clock.
  task automatic step(input logic zv, input logic [31:0] zd, input logic rdy);
    logic        v, l, cap, xfer;
    logic [31:0] d, cap_d;
    int          hr;
    v = out_valid; d = out_data; l = out_last;

    check("overflow", overflow, m_ovf);
    if (comp_q.size() == 0) begin
      check("valid_idle", v, 0);
    end else begin
      hr = (comp_q[0] > prev_rel) ? comp_q[0] : prev_rel;
      if (hr <= cyc - 2) check("valid_latency", v, 1);
    end
    if (prev_stall) begin
      check("stall_valid", v, 1);
      check("stall_data", d, prev_d);
      check("stall_last", l, prev_l);
    end

    cap   = hist_v[LAT-1];
    cap_d = relu(hist_d[LAT-1]);
    z_valid   = zv;
    out_ready = rdy;
    a         = cap_d;
    for (int i = LAT - 1; i > 0; i--) begin
      hist_v[i] = hist_v[i-1];
      hist_d[i] = hist_d[i-1];
    end
    hist_v[0] = zv;
    hist_d[0] = zd;

    xfer = v & rdy;
    if (xfer) begin
      check("xfer_has_word", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        check("out_data", d, exp_q.pop_front());
        check("out_last", l, out_pos == DEPTH - 1);
      end
      out_log.push_back(d);
      last_log.push_back(l);
      if (l) last_cnt++;
      out_pos++;
      if (out_pos == DEPTH) begin
        out_pos = 0;
        if (comp_q.size() > 0) void'(comp_q.pop_front());
        prev_rel = cyc;
      end
    end
    if (cap) begin
      if (comp_q.size() == 2) begin
        m_ovf = 1'b1;
      end else begin
        exp_q.push_back(cap_d);
        fill_cnt++;
        if (fill_cnt == DEPTH) begin
          fill_cnt = 0;
          comp_q.push_back(cyc);
        end
      end
    end
    prev_stall = v & ~rdy;
    prev_d = d;
    prev_l = l;

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] t2 [9];
    logic [31:0] t3 [4];
    logic [31:0] t4 [4];

    clear_model();

    // Test 1: table-driven single vector, out_ready tied high
    for (int i = 0; i < 14; i++) begin
      tbl[i] = '{zv: 1'b0, zd: F0, rdy: 1'b1, ev: 1'b0, ed: F0, el: 1'b0};
    end
    tbl[0].zv = 1'b1; tbl[0].zd = F1;
    tbl[1].zv = 1'b1; tbl[1].zd = F2;
    tbl[2].zv = 1'b1; tbl[2].zd = F0;
    tbl[3].zv = 1'b1; tbl[3].zd = F3;
    tbl[8].ev  = 1'b1; tbl[8].ed  = F1;
    tbl[9].ev  = 1'b1; tbl[9].ed  = F2;
    tbl[10].ev = 1'b1; tbl[10].ed = F0;
    tbl[11].ev = 1'b1; tbl[11].ed = F3; tbl[11].el = 1'b1;

    do_reset();
    for (int i = 0; i < 14; i++) begin
      check("t1_valid", out_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        check("t1_data", out_data, tbl[i].ed);
        check("t1_last", out_last, tbl[i].el);
      end
      step(tbl[i].zv, tbl[i].zd, tbl[i].rdy);
    end

    // Test 2: fill both banks while stalled, then overflow on the 9th word
    do_reset();
    for (int i = 0; i < 9; i++) t2[i] = 32'h4200_0000 + 32'(i);
    for (int i = 0; i < 8; i++) step(1'b1, t2[i], 1'b0);
    repeat (4) step(1'b0, F0, 1'b0);
    check("t2_no_ovf", overflow, 0);
    check("t2_valid_stalled", out_valid, 1);
    step(1'b1, t2[8], 1'b0);
    repeat (4) step(1'b0, F0, 1'b0);
    check("t2_ovf", overflow, 1);
    repeat (20) step(1'b0, F0, 1'b1);
    check("t2_count", out_log.size(), 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) check("t2_order", out_log[i], t2[i]);
    check("t2_ovf_sticky", overflow, 1);

    // Test 3: out_ready toggling during drain
    do_reset();
    t3 = '{32'h3F00_0001, 32'h3F00_0002, 32'h3F00_0003, 32'h3F00_0004};
    for (int i = 0; i < 4; i++) step(1'b1, t3[i], 1'b0);
    repeat (5) step(1'b0, F0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, F0, (i % 2) == 0);
    check("t3_count", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) check("t3_order", out_log[i], t3[i]);

    // Test 4: reset with a half-filled bank, then a clean vector
    do_reset();
    step(1'b1, F1, 1'b1);
    step(1'b1, F2, 1'b1);
    repeat (4) step(1'b0, F0, 1'b1);
    do_reset();
    t4 = '{F5, F6, F7, F8};
    for (int i = 0; i < 4; i++) step(1'b1, t4[i], 1'b1);
    repeat (10) step(1'b0, F0, 1'b1);
    check("t4_count", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) check("t4_order", out_log[i], t4[i]);
    check("t4_last_cnt", last_cnt, 1);
    if (last_log.size() == 4) check("t4_last_pos", last_log[3], 1);

    // Test 5: continuous streaming, 64 activations
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b1, 32'h3C00_0000 + 32'(i), 1'b1);
    repeat (12) step(1'b0, F0, 1'b1);
    check("t5_count", out_log.size(), 64);
    check("t5_last_cnt", last_cnt, 16);
    check("t5_no_ovf", overflow, 0);

    // Randomized traffic including negative z and back-pressure
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 60);
    end
    repeat (30) step(1'b0, F0, 1'b1);
    check("rand_residual", exp_q.size(), fill_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/act_collect_buffer.md
ACT_COLLECT_BUFFER -- requirements
Module: act_collect_buffer

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of one activation word (IEEE-754 single).
REQ-002 Parameter DEPTH, 16, activations per layer vector; power of two, 2..256.
REQ-003 Parameter RELU_LAT, 3, cycles from z entering the upstream ReLU stage to its activation appearing on a.
REQ-004 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 z_valid  input  1  high in the cycle z is presented to the upstream ReLU stage.
REQ-007 a  input  DATA_WIDTH  ReLU activation output.
REQ-008 out_data  output  DATA_WIDTH  activation word to the next layer.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 out_last  output  1  high with the final word (index DEPTH-1) of a vector.
REQ-012 overflow  output  1  sticky flag: an activation was dropped.

Function
REQ-013 z_valid SHALL pass through a RELU_LAT-stage shift register; its final stage (cap_en) marks cycles in which a is captured.
REQ-014 Storage SHALL be two banks (0, 1) of DEPTH words each, used ping-pong.
REQ-015 Each bank SHALL have a state EMPTY, FILLING or FULL.
REQ-016 Fill side: on cap_en, write a into fill bank at wr_idx, increment wr_idx, and set the bank to FILLING.
REQ-017 At wr_idx = DEPTH-1 with cap_en, the fill bank SHALL become FULL, wr_idx wrap to 0, and fill-bank select toggle.
REQ-018 If cap_en occurs while the fill bank is FULL (both banks FULL), the word SHALL be dropped, overflow set, and wr_idx held.
REQ-019 Drain side: out_valid SHALL be high only while the drain bank is FULL; out_data = drain bank[rd_idx], registered.
REQ-020 A transfer occurs when out_valid and out_ready are both high; on a transfer rd_idx increments.
REQ-021 On a transfer with rd_idx = DEPTH-1, out_last SHALL be high, the bank SHALL become EMPTY, rd_idx wrap to 0, and drain select toggle.
REQ-022 out_data, out_last SHALL be held stable while out_valid is high and out_ready is low.
REQ-023 Latency: the first word of a vector SHALL appear on out_valid no later than 2 cycles after the cap_en completing that vector.
REQ-024 Simultaneous completion of a fill in one bank and drain of the other in the same cycle SHALL both take effect, with no dropped word.
REQ-025 With both banks EMPTY, a vector SHALL stream with out_ready tied high and no bubble after its first word.
REQ-026 Storage SHALL be indexed modulo DEPTH; indices are $clog2(DEPTH) bits.

Reset
REQ-027 On rst low: delay line, wr_idx, rd_idx and both selects = 0; both banks EMPTY; out_valid, out_last, overflow = 0; out_data = 0.
REQ-028 Reset mid-vector SHALL discard all partial and full banks; bank contents need not be cleared.
REQ-029 overflow SHALL clear only on reset.

Structure
REQ-030 Shared package act_pkg SHALL hold the bank state enum (EMPTY/FILLING/FULL) and the DATA_WIDTH default.
REQ-031 One sub-module, valid_delay_line (parameter LAT), SHALL implement REQ-013 with the same reset.
REQ-032 Banks SHALL be inferred as registers or distributed RAM with a synchronous write and a registered read.

Verification
REQ-033 Bench SHALL model the upstream ReLU as a RELU_LAT-cycle delay; all scenarios use DEPTH=4, RELU_LAT=3.
REQ-034 Test 1: 4 z_valid pulses, activations 1.0, 2.0, 0.0, 3.0, out_ready=1 -> out_data 1.0, 2.0, 0.0, 3.0, with out_last on 3.0.
REQ-035 Test 2: 8 back-to-back activations, out_ready=0 -> both banks FULL, overflow=0; 9th activation -> overflow=1; release out_ready -> exactly 8 words in order.
REQ-036 Test 3: out_ready toggling 1,0,1,0 during drain -> each word held while stalled, no duplicates or losses.
REQ-037 Test 4: rst low after 2 of 4 activations -> all outputs 0; next 4 activations 5.0..8.0 emerge as one clean vector.
REQ-038 Test 5: continuous z_valid with out_ready=1 for 64 activations -> 16 vectors, overflow=0, and an out_last on every 4th word.
